// File: rtl/adc_pkg.sv
// adc_pkg
//   Constants and helpers shared by the ADC-to-millivolt converter.
//   ACC_GUARD_W   : extra accumulator bits above the output width
//                   (covers the largest window of 64 samples plus sign margin)
//   MAX_AVG_LOG2  : largest supported window exponent; larger requests saturate
//   midscale()    : offset-binary zero code for a given ADC width
//   acc_width()   : accumulator width for a given output width
//   clamp_s()     : clamp a signed value into [lo, hi]
//   sat_s()       : saturate a signed value to a w-bit two's-complement range
//   lim_avg()     : limit a window exponent to MAX_AVG_LOG2
package adc_pkg;

  localparam int         ACC_GUARD_W  = 7;
  localparam logic [2:0] MAX_AVG_LOG2 = 3'd6;

  function automatic int midscale(input int adc_w);
    return 1 << (adc_w - 1);
  endfunction

  function automatic int acc_width(input int out_w);
    return out_w + ACC_GUARD_W;
  endfunction

  function automatic logic signed [63:0] clamp_s(input logic signed [63:0] v,
                                                 input logic signed [63:0] lo,
                                                 input logic signed [63:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                               input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return clamp_s(v, lo, hi);
  endfunction

  function automatic logic [2:0] lim_avg(input logic [2:0] a);
    return (a > MAX_AVG_LOG2) ? MAX_AVG_LOG2 : a;
  endfunction

endpackage

// File: rtl/adc_ch_scale.sv
// adc_ch_scale
//   Per-channel front end: offset add with clamp, midscale removal, and
//   scaling to signed millivolts. Three register stages.
//   ad_clk_i  : clock (rising edge)
//   rst_i     : synchronous active-high reset
//   code_i    : raw offset-binary ADC code
//   offset_i  : signed offset in code LSBs
//   mv_o      : signed millivolt result (stage 3 register)
//   ovr_o     : sample was clamped, or the raw code sat at a rail
module adc_ch_scale
  import adc_pkg::*;
#(
  parameter int ADC_W = 12,
  parameter int OUT_W = 16,
  parameter int SCALE = 8000,
  parameter int SHIFT = 13
) (
  input  logic                    ad_clk_i,
  input  logic                    rst_i,
  input  logic [ADC_W-1:0]        code_i,
  input  logic [ADC_W-1:0]        offset_i,
  output logic signed [OUT_W-1:0] mv_o,
  output logic                    ovr_o
);

  // Product width covers the full |d| * SCALE range with no loss.
  localparam int                     PW       = ADC_W + 33;
  localparam logic signed [63:0]     CODE_MAX = (64'sd1 <<< ADC_W) - 64'sd1;
  localparam logic signed [ADC_W:0]  MID      = (ADC_W+1)'(midscale(ADC_W));

  logic signed [63:0]      sum_w;
  logic signed [ADC_W:0]   s1_d, s1_q;
  logic signed [ADC_W:0]   s2_d, s2_q;
  logic                    s1_ovr_d, s1_ovr_q, s2_ovr_q;
  logic [ADC_W:0]          mag;
  logic [PW-1:0]           prod, quot;
  logic signed [63:0]      mv_w;
  logic signed [OUT_W-1:0] mv_d, mv_q;
  logic                    ovr_q;

  always_comb begin
    sum_w    = 64'($signed({1'b0, code_i})) + 64'($signed(offset_i));
    s1_d     = (ADC_W+1)'(clamp_s(sum_w, 64'sd0, CODE_MAX));
    s1_ovr_d = (sum_w < 0) || (sum_w > CODE_MAX) ||
               (code_i == '0) || (code_i == '1);
    s2_d     = s1_q - MID;
    // Scale the magnitude so the shift truncates toward zero for both signs.
    mag      = s2_q[ADC_W] ? $unsigned(-s2_q) : $unsigned(s2_q);
    prod     = PW'(mag) * PW'(SCALE);
    quot     = prod >> SHIFT;
    mv_w     = s2_q[ADC_W] ? -$signed(64'(quot)) : $signed(64'(quot));
    mv_d     = OUT_W'(sat_s(mv_w, OUT_W));
  end

  always_ff @(posedge ad_clk_i) begin
    if (rst_i) begin
      s1_q     <= '0;
      s1_ovr_q <= 1'b0;
      s2_q     <= '0;
      s2_ovr_q <= 1'b0;
      mv_q     <= '0;
      ovr_q    <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s1_ovr_q <= s1_ovr_d;
      s2_q     <= s2_d;
      s2_ovr_q <= s1_ovr_q;
      mv_q     <= mv_d;
      ovr_q    <= s2_ovr_q;
    end
  end

  assign mv_o  = mv_q;
  assign ovr_o = ovr_q;

endmodule

// File: rtl/adc_volt_conv.sv
// adc_volt_conv
//   Multi-channel ADC code to signed millivolt converter with per-channel
//   offset trim and power-of-two window averaging.
//   ad_clk     : clock (rising edge)
//   rst        : synchronous active-high reset
//   ad_in      : raw codes, channel k at [k*ADC_W +: ADC_W], sampled every cycle
//   cfg_wr     : offset write strobe
//   cfg_ch     : offset write channel (out-of-range indices are ignored)
//   cfg_offset : signed offset in code LSBs
//   avg_log2   : window exponent (0..6, 7 behaves as 6)
//   volt       : averaged signed mV per channel, held between strobes
//   volt_vld   : one-cycle strobe per completed window
//   ovr        : per-channel over-range flag for the reported window
module adc_volt_conv
  import adc_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int ADC_W      = 12,
  parameter int OUT_W      = 16,
  parameter int SCALE      = 8000,
  parameter int SHIFT      = 13,
  parameter int DEF_OFFSET = 0
) (
  input  logic                                  ad_clk,
  input  logic                                  rst,
  input  logic [NCH*ADC_W-1:0]                  ad_in,
  input  logic                                  cfg_wr,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch,
  input  logic [ADC_W-1:0]                      cfg_offset,
  input  logic [2:0]                            avg_log2,
  output logic [NCH*OUT_W-1:0]                  volt,
  output logic                                  volt_vld,
  output logic [NCH-1:0]                        ovr
);

  localparam int ACC_W = acc_width(OUT_W);

  logic [ADC_W-1:0]        off_q [NCH];
  logic [2:0]              vld_q;
  logic signed [OUT_W-1:0] mv [NCH];
  logic [NCH-1:0]          s3_ovr;

  logic [5:0]              cnt_q, cnt_d;
  logic [2:0]              avg_q, avg_d, log2_eff;
  logic [6:0]              win_len;
  logic                    win_last;
  logic signed [ACC_W-1:0] acc_q [NCH];
  logic signed [ACC_W-1:0] acc_d [NCH];
  logic signed [ACC_W-1:0] acc_sum [NCH];
  logic [NCH-1:0]          ovr_acc_q, ovr_acc_d, ovr_sum, ovr_q, ovr_d;
  logic [NCH*OUT_W-1:0]    volt_q, volt_d;
  logic                    vld_o_q, vld_o_d;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    adc_ch_scale #(
      .ADC_W (ADC_W),
      .OUT_W (OUT_W),
      .SCALE (SCALE),
      .SHIFT (SHIFT)
    ) u_ch (
      .ad_clk_i (ad_clk),
      .rst_i    (rst),
      .code_i   (ad_in[k*ADC_W +: ADC_W]),
      .offset_i (off_q[k]),
      .mv_o     (mv[k]),
      .ovr_o    (s3_ovr[k])
    );
  end

  always_ff @(posedge ad_clk) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) off_q[k] <= ADC_W'(DEF_OFFSET);
    end else if (cfg_wr && (int'(cfg_ch) < NCH)) begin
      off_q[cfg_ch] <= cfg_offset;
    end
  end

  // The window size is taken from avg_log2 only while the counter sits at 0,
  // so a change mid-window applies from the next window on.
  always_comb begin
    log2_eff  = (cnt_q == '0) ? lim_avg(avg_log2) : avg_q;
    win_len   = 7'd1 << log2_eff;
    win_last  = ({1'b0, cnt_q} == (win_len - 7'd1));
    cnt_d     = cnt_q;
    avg_d     = avg_q;
    vld_o_d   = 1'b0;
    volt_d    = volt_q;
    ovr_d     = ovr_q;
    ovr_acc_d = ovr_acc_q;
    for (int k = 0; k < NCH; k++) begin
      acc_d[k] = acc_q[k];
      if (cnt_q == '0) begin
        acc_sum[k] = {{(ACC_W-OUT_W){mv[k][OUT_W-1]}}, mv[k]};
        ovr_sum[k] = s3_ovr[k];
      end else begin
        acc_sum[k] = acc_q[k] + {{(ACC_W-OUT_W){mv[k][OUT_W-1]}}, mv[k]};
        ovr_sum[k] = ovr_acc_q[k] | s3_ovr[k];
      end
    end
    if (vld_q[2]) begin
      avg_d     = log2_eff;
      ovr_acc_d = ovr_sum;
      for (int k = 0; k < NCH; k++) acc_d[k] = acc_sum[k];
      if (win_last) begin
        cnt_d   = '0;
        vld_o_d = 1'b1;
        ovr_d   = ovr_sum;
        for (int k = 0; k < NCH; k++) begin
          volt_d[k*OUT_W +: OUT_W] =
            OUT_W'(sat_s(64'(acc_sum[k] >>> log2_eff), OUT_W));
        end
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge ad_clk) begin
    if (rst) begin
      vld_q     <= '0;
      cnt_q     <= '0;
      avg_q     <= '0;
      ovr_acc_q <= '0;
      ovr_q     <= '0;
      volt_q    <= '0;
      vld_o_q   <= 1'b0;
      for (int k = 0; k < NCH; k++) acc_q[k] <= '0;
    end else begin
      vld_q     <= {vld_q[1:0], 1'b1};
      cnt_q     <= cnt_d;
      avg_q     <= avg_d;
      ovr_acc_q <= ovr_acc_d;
      ovr_q     <= ovr_d;
      volt_q    <= volt_d;
      vld_o_q   <= vld_o_d;
      for (int k = 0; k < NCH; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign volt     = volt_q;
  assign volt_vld = vld_o_q;
  assign ovr      = ovr_q;

endmodule

// File: doc/adc_volt_conv.md
ADC_VOLT_CONV -- requirements
Module: adc_volt_conv

Interface
REQ-001 SHALL have parameter NCH, default 2, number of ADC channels (1..8).
REQ-002 SHALL have parameter ADC_W, default 12, raw ADC code width (offset-binary).
REQ-003 SHALL have parameter OUT_W, default 16, signed mV output width.
REQ-004 SHALL have parameters SCALE, default 8000, and SHIFT, default 13, giving mV = (code-midscale)*SCALE>>SHIFT.
REQ-005 SHALL have parameter DEF_OFFSET, default 0, signed reset value of every channel offset.
REQ-006 SHALL have port ad_clk, in, 1, sole clock, all logic rising-edge.
REQ-007 SHALL have port rst, in, 1, synchronous active-high reset.
REQ-008 SHALL have port ad_in, in, NCH*ADC_W, raw codes, channel k at bits [k*ADC_W +: ADC_W].
REQ-009 SHALL have port cfg_wr, in, 1, offset write strobe.
REQ-010 SHALL have port cfg_ch, in, max(1,clog2(NCH)), offset write channel index.
REQ-011 SHALL have port cfg_offset, in, ADC_W, signed two's-complement offset in code LSBs.
REQ-012 SHALL have port avg_log2, in, 3, averaging window exponent (window = 2^avg_log2 samples, 0..6; 7 treated as 6).
REQ-013 SHALL have port volt, out, NCH*OUT_W, signed mV per channel, same packing as ad_in.
REQ-014 SHALL have port volt_vld, out, 1, one-cycle strobe marking a new volt word.
REQ-015 SHALL have port ovr, out, NCH, per-channel over-range flag for the window just reported.

Function
REQ-016 SHALL sample ad_in every cycle; no input handshake.
REQ-017 Stage 1 SHALL register code+offset at ADC_W+1 bits signed, clamping to [0, 2^ADC_W-1].
REQ-018 Stage 2 SHALL form d = clamped - 2^(ADC_W-1), signed ADC_W+1 bits.
REQ-019 Stage 3 SHALL compute mV = sign(d)*((|d|*SCALE)>>SHIFT), truncation toward zero, full-width product.
REQ-020 Stage 4 SHALL accumulate mV per channel over the window in an accumulator of OUT_W+7 bits.
REQ-021 At window end SHALL output acc>>>avg_log2 (arithmetic, floor), saturated to OUT_W signed range, assert volt_vld for exactly one cycle.
REQ-022 volt SHALL hold its last value between strobes.
REQ-023 With avg_log2=0, latency ad_in->volt SHALL be 4 cycles, volt_vld high every cycle once the pipeline is full.
REQ-024 A window counter SHALL run 0..2^avg_log2-1 and wrap; avg_log2 SHALL be latched only when the counter is 0; mid-window changes take effect next window.
REQ-025 ovr[k] SHALL set if any sample in the window was clamped in stage 1 or the raw code was 0 or all-ones; it SHALL be presented with volt_vld and cleared at window start.
REQ-026 cfg_wr SHALL update offset[cfg_ch] at the clock edge, affecting stage 1 on the following cycle; cfg_ch >= NCH SHALL be ignored.
REQ-027 Simultaneous cfg_wr and window end SHALL both complete without interaction.

Reset
REQ-028 rst SHALL clear volt, volt_vld, ovr, accumulators, and window counter to 0, and set all offsets to DEF_OFFSET.
REQ-029 rst SHALL clear pipeline valid bits so no volt_vld occurs until 3 cycles after rst deasserts plus one full window.
REQ-030 rst mid-window SHALL discard the partial window; no strobe for it.

Structure
REQ-031 Package adc_pkg SHALL hold the midscale, accumulator-width, and max-avg_log2 constants, plus the clamp/saturate helper functions.
REQ-032 Sub-module adc_ch_scale SHALL implement stages 1-3 for one channel, instantiated NCH times; the top SHALL hold the offset bank, window counter, and accumulators.

Verification (NCH=2, ADC_W=12, defaults)
REQ-033 avg_log2=0, offsets 0, ch0=3072, ch1=1024 -> after 4 cycles volt ch0=+1000, ch1=-1000, vld every cycle.
REQ-034 Codes 0 and 4095 -> -2000 and +1999, ovr=1 on both.
REQ-035 cfg_wr ch0 offset=+80, code 4090 -> clamped 4095, +1999, ovr[0]=1; cfg_ch=2 write -> no offset change.
REQ-036 avg_log2=2, ch0 sequence 3072,3072,1024,1024 -> single strobe, volt=0; vld every 4th cycle.
REQ-037 avg_log2=2, rst asserted after 2 samples -> no strobe for that window; first strobe 3+4 cycles after release.
REQ-038 avg_log2 changed 2->0 mid-window -> current window completes at 4 samples, then strobes every cycle.
